// File: rtl/signal_conflict_monitor.sv
// Purpose: passes controller light codes to the lamps; trips to flashing yellow on a conflict, an illegal code or a stall.
// Latency: 1 cycle from input code to lamp in NORMAL; faults confirm after FILTER_CYCLES / WATCHDOG_CYCLES cycles.
// Backpressure: none; every cycle is sampled, and a fault_clr that is not accepted is dropped.
module signal_conflict_monitor #(
    parameter int unsigned FILTER_CYCLES   = 4,
    parameter int unsigned WATCHDOG_CYCLES = 400_000_000,
    parameter int unsigned FLASH_HALF      = 25_000_000,
    parameter int unsigned ALL_RED_CYCLES  = 100_000_000,
    parameter logic [14:0] CONFLICT_MASK   = 15'h2CFC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] w_to_e_in,
    input  logic [2:0] w_to_n_in,
    input  logic [2:0] e_to_w_in,
    input  logic [2:0] e_to_n_in,
    input  logic [2:0] n_to_e_in,
    input  logic [2:0] n_to_w_in,
    input  logic       fault_clr,
    output logic [2:0] w_to_e,
    output logic [2:0] w_to_n,
    output logic [2:0] e_to_w,
    output logic [2:0] e_to_n,
    output logic [2:0] n_to_e,
    output logic [2:0] n_to_w,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam logic [2:0] RED        = 3'b100;
    localparam logic [2:0] YELLOW     = 3'b010;
    localparam logic [2:0] GREEN      = 3'b001;
    localparam logic [2:0] RED_YELLOW = 3'b110;
    localparam logic [2:0] DARK       = 3'b000;

    localparam logic [31:0] F_LAST  = 32'(FILTER_CYCLES - 1);
    localparam logic [31:0] F_MAX   = 32'(FILTER_CYCLES);
    localparam logic [31:0] WD_LAST = 32'(WATCHDOG_CYCLES - 1);
    localparam logic [31:0] FH_LAST = 32'(FLASH_HALF - 1);
    localparam logic [31:0] AR_LAST = 32'(ALL_RED_CYCLES - 1);

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        FLASH   = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  code_in [6];
    logic [2:0]  prev_in [6];
    logic [2:0]  lamp_q  [6];
    logic [5:0]  act;
    logic [5:0]  bad;
    logic [14:0] pair_hit;
    logic        conflict_viol;
    logic        illegal_viol;
    logic        changed;
    logic [31:0] conf_cnt;
    logic [31:0] ill_cnt;
    logic [31:0] wd_cnt;
    logic [31:0] flash_cnt;
    logic [31:0] rec_cnt;
    logic        flash_on;
    logic        conflict_hit;
    logic        illegal_hit;
    logic        wd_hit;
    logic [1:0]  hit_code;

    assign code_in[0] = w_to_e_in;
    assign code_in[1] = w_to_n_in;
    assign code_in[2] = e_to_w_in;
    assign code_in[3] = e_to_n_in;
    assign code_in[4] = n_to_e_in;
    assign code_in[5] = n_to_w_in;

    assign w_to_e = lamp_q[0];
    assign w_to_n = lamp_q[1];
    assign e_to_w = lamp_q[2];
    assign e_to_n = lamp_q[3];
    assign n_to_e = lamp_q[4];
    assign n_to_w = lamp_q[5];

    // A movement is active on GREEN or YELLOW; anything outside the four defined codes is illegal
    genvar gi, gj;
    for (gi = 0; gi < 6; gi++) begin : g_lamp
        assign act[gi] = (code_in[gi] == GREEN) || (code_in[gi] == YELLOW);
        assign bad[gi] = !(code_in[gi] inside {RED, YELLOW, GREEN, RED_YELLOW});
    end

    // Pair (i,j), i<j, maps to bit i*(11-i)/2 + (j-i-1) of the conflict mask
    for (gi = 0; gi < 5; gi++) begin : g_row
        for (gj = gi + 1; gj < 6; gj++) begin : g_col
            assign pair_hit[gi*(11-gi)/2 + gj-gi-1] = act[gi] & act[gj];
        end
    end

    assign conflict_viol = |(pair_hit & CONFLICT_MASK);
    assign illegal_viol  = |bad;

    // Any input code differing from last cycle counts as controller activity
    always_comb begin
        changed = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (code_in[i] != prev_in[i]) changed = 1'b1;
        end
    end

    // Fault confirmation on the FILTER_CYCLES-th consecutive violating cycle, watchdog only in NORMAL
    always_comb begin
        conflict_hit = conflict_viol && (conf_cnt >= F_LAST);
        illegal_hit  = illegal_viol && (ill_cnt >= F_LAST);
        wd_hit       = (state == NORMAL) && !changed && (wd_cnt == WD_LAST);
        if (conflict_hit)     hit_code = 2'b01;
        else if (illegal_hit) hit_code = 2'b10;
        else if (wd_hit)      hit_code = 2'b11;
        else                  hit_code = 2'b00;
    end

    // Previous-cycle copy of the inputs for stall detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 6; i++) prev_in[i] <= DARK;
        end else begin
            for (int i = 0; i < 6; i++) prev_in[i] <= code_in[i];
        end
    end

    // Saturating glitch filters, cleared by any clean cycle; they run in every state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conf_cnt <= '0;
            ill_cnt  <= '0;
        end else begin
            if (!conflict_viol)        conf_cnt <= '0;
            else if (conf_cnt != F_MAX) conf_cnt <= conf_cnt + 32'd1;
            if (!illegal_viol)         ill_cnt  <= '0;
            else if (ill_cnt != F_MAX)  ill_cnt  <= ill_cnt + 32'd1;
        end
    end

    // Stall watchdog: counts unchanged cycles in NORMAL, parked at zero elsewhere
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                             wd_cnt <= '0;
        else if (state != NORMAL || changed)  wd_cnt <= '0;
        else if (wd_cnt != WD_LAST)           wd_cnt <= wd_cnt + 32'd1;
    end

    // Main FSM with registered lamp outputs; reset lands in the all-red recovery hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RECOVER;
            fault      <= 1'b0;
            fault_code <= 2'b00;
            flash_cnt  <= '0;
            flash_on   <= 1'b0;
            rec_cnt    <= '0;
            for (int i = 0; i < 6; i++) lamp_q[i] <= RED;
        end else begin
            case (state)
                NORMAL: begin
                    if (hit_code != 2'b00) begin
                        state      <= FLASH;
                        fault      <= 1'b1;
                        fault_code <= hit_code;
                        flash_cnt  <= '0;
                        flash_on   <= 1'b1;
                        for (int i = 0; i < 6; i++) lamp_q[i] <= YELLOW;
                    end else begin
                        for (int i = 0; i < 6; i++) lamp_q[i] <= code_in[i];
                    end
                end
                FLASH: begin
                    if (fault_clr && !conflict_viol && !illegal_viol) begin
                        state      <= RECOVER;
                        fault      <= 1'b0;
                        fault_code <= 2'b00;
                        rec_cnt    <= '0;
                        for (int i = 0; i < 6; i++) lamp_q[i] <= RED;
                    end else if (flash_cnt == FH_LAST) begin
                        flash_cnt <= '0;
                        flash_on  <= !flash_on;
                        for (int i = 0; i < 6; i++) lamp_q[i] <= flash_on ? DARK : YELLOW;
                    end else begin
                        flash_cnt <= flash_cnt + 32'd1;
                    end
                end
                RECOVER: begin
                    if (hit_code != 2'b00) begin
                        state      <= FLASH;
                        fault      <= 1'b1;
                        fault_code <= hit_code;
                        flash_cnt  <= '0;
                        flash_on   <= 1'b1;
                        for (int i = 0; i < 6; i++) lamp_q[i] <= YELLOW;
                    end else if (rec_cnt == AR_LAST) begin
                        state   <= NORMAL;
                        rec_cnt <= '0;
                        for (int i = 0; i < 6; i++) lamp_q[i] <= code_in[i];
                    end else begin
                        rec_cnt <= rec_cnt + 32'd1;
                    end
                end
                default: begin
                    state <= RECOVER;
                    fault <= 1'b0;
                    for (int i = 0; i < 6; i++) lamp_q[i] <= RED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Purpose: directed checks of pass-through, fault filters, priority, watchdog, flash, clear, recovery and reset.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: none; stimulus is applied every cycle.
module tb_signal_conflict_monitor;

    localparam logic [2:0] R  = 3'b100;
    localparam logic [2:0] Y  = 3'b010;
    localparam logic [2:0] G  = 3'b001;
    localparam logic [2:0] IL = 3'b111;

    // Lamp order in every 18-bit vector: w_to_e, w_to_n, e_to_w, e_to_n, n_to_e, n_to_w
    localparam logic [17:0] ALL_R  = {R, R, R, R, R, R};
    localparam logic [17:0] ALL_Y  = {Y, Y, Y, Y, Y, Y};
    localparam logic [17:0] ALL_D  = 18'd0;
    localparam logic [17:0] PAT_A  = {G, R, G, R, R, R};
    localparam logic [17:0] PAT_B  = {R, R, R, R, R, R};
    localparam logic [17:0] CONF04 = {G, R, R, R, G, R};
    localparam logic [17:0] ILL3   = {G, R, G, IL, R, R};
    localparam logic [17:0] PRI    = {G, R, R, G, R, IL};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] w_to_e_in, w_to_n_in, e_to_w_in, e_to_n_in, n_to_e_in, n_to_w_in;
    logic       fault_clr = 1'b0;
    logic [2:0] w_to_e, w_to_n, e_to_w, e_to_n, n_to_e, n_to_w;
    logic       fault;
    logic [1:0] fault_code;
    logic [17:0] outs;

    int n_cmp = 0;
    int n_err = 0;

    assign outs = {w_to_e, w_to_n, e_to_w, e_to_n, n_to_e, n_to_w};

    signal_conflict_monitor #(
        .FILTER_CYCLES  (4),
        .WATCHDOG_CYCLES(64),
        .FLASH_HALF     (8),
        .ALL_RED_CYCLES (16),
        .CONFLICT_MASK  (15'h2CFC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .w_to_e_in (w_to_e_in),
        .w_to_n_in (w_to_n_in),
        .e_to_w_in (e_to_w_in),
        .e_to_n_in (e_to_n_in),
        .n_to_e_in (n_to_e_in),
        .n_to_w_in (n_to_w_in),
        .fault_clr (fault_clr),
        .w_to_e    (w_to_e),
        .w_to_n    (w_to_n),
        .e_to_w    (e_to_w),
        .e_to_n    (e_to_n),
        .n_to_e    (n_to_e),
        .n_to_w    (n_to_w),
        .fault     (fault),
        .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [17:0] v);
        {w_to_e_in, w_to_n_in, e_to_w_in, e_to_n_in, n_to_e_in, n_to_w_in} = v;
    endtask

    task automatic test_reset();
        drive(PAT_B);
        rst = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({fault, fault_code, outs} !== {3'b000, ALL_R}) begin
            n_err++;
            $display("FAIL reset_state: got %b required %b", {fault, fault_code, outs}, {3'b000, ALL_R});
        end
    endtask

    // Reset release: 16 red cycles, then inputs tracked with one cycle of delay
    task automatic test_startup();
        logic [17:0] last;
        logic [17:0] cur;
        logic [17:0] exp;
        rst = 1'b1;
        drive(PAT_A);
        last = PAT_A;
        n_cmp++;
        if ({fault, fault_code, outs} !== {3'b000, ALL_R}) begin
            n_err++;
            $display("FAIL startup_c0: got %b required %b", {fault, fault_code, outs}, {3'b000, ALL_R});
        end
        for (int c = 1; c <= 40; c++) begin
            tick();
            exp = (c < 16) ? ALL_R : last;
            n_cmp++;
            if ({fault, fault_code, outs} !== {3'b000, exp}) begin
                n_err++;
                $display("FAIL startup_c%0d: got %b required %b", c, {fault, fault_code, outs}, {3'b000, exp});
            end
            cur = ((c / 10) % 2 == 1) ? PAT_B : PAT_A;
            drive(cur);
            last = cur;
        end
    endtask

    // Accepts a clear with clean inputs v, checks the 16-cycle red hold and the return to NORMAL
    task automatic clear_and_recover(input logic [17:0] v);
        drive(v);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        n_cmp++;
        if ({fault, fault_code, outs} !== {3'b000, ALL_R}) begin
            n_err++;
            $display("FAIL clear_accept: got %b required %b", {fault, fault_code, outs}, {3'b000, ALL_R});
        end
        for (int i = 1; i <= 15; i++) begin
            tick();
            n_cmp++;
            if ({fault, outs} !== {1'b0, ALL_R}) begin
                n_err++;
                $display("FAIL recover_red_%0d: got %b required %b", i, {fault, outs}, {1'b0, ALL_R});
            end
        end
        tick();
        n_cmp++;
        if ({fault, fault_code, outs} !== {3'b000, v}) begin
            n_err++;
            $display("FAIL recover_to_normal: got %b required %b", {fault, fault_code, outs}, {3'b000, v});
        end
    endtask

    task automatic test_conflict();
        logic [17:0] exp;
        drive(CONF04);
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++;
            if ({fault, fault_code, outs} !== {3'b000, CONF04}) begin
                n_err++;
                $display("FAIL conflict_short_%0d: got %b required %b", i, {fault, fault_code, outs}, {3'b000, CONF04});
            end
        end
        drive(PAT_A);
        tick();
        n_cmp++;
        if ({fault, outs} !== {1'b0, PAT_A}) begin
            n_err++;
            $display("FAIL conflict_gap: got %b required %b", {fault, outs}, {1'b0, PAT_A});
        end
        drive(CONF04);
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++;
            if (fault !== 1'b0) begin
                n_err++;
                $display("FAIL conflict_filter_%0d: fault got %b required 0", i, fault);
            end
        end
        tick();
        n_cmp++;
        if ({fault, fault_code, outs} !== {3'b101, ALL_Y}) begin
            n_err++;
            $display("FAIL conflict_confirm: got %b required %b", {fault, fault_code, outs}, {3'b101, ALL_Y});
        end
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp = ((k / 8) % 2 == 0) ? ALL_Y : ALL_D;
            n_cmp++;
            if ({fault, fault_code, outs} !== {3'b101, exp}) begin
                n_err++;
                $display("FAIL flash_k%0d: got %b required %b", k, {fault, fault_code, outs}, {3'b101, exp});
            end
        end
    endtask

    task automatic test_clear_ignored();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        n_cmp++;
        if ({fault, fault_code} !== 3'b101) begin
            n_err++;
            $display("FAIL clear_blocked: got %b required 101", {fault, fault_code});
        end
        drive(PAT_A);
        tick();
        n_cmp++;
        if ({fault, fault_code} !== 3'b101) begin
            n_err++;
            $display("FAIL clear_not_remembered: got %b required 101", {fault, fault_code});
        end
        clear_and_recover(PAT_A);
    endtask

    task automatic test_illegal();
        drive(ILL3);
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++;
            if ({fault, outs} !== {1'b0, ILL3}) begin
                n_err++;
                $display("FAIL illegal_filter_%0d: got %b required %b", i, {fault, outs}, {1'b0, ILL3});
            end
        end
        tick();
        n_cmp++;
        if ({fault, fault_code, outs} !== {3'b110, ALL_Y}) begin
            n_err++;
            $display("FAIL illegal_confirm: got %b required %b", {fault, fault_code, outs}, {3'b110, ALL_Y});
        end
        clear_and_recover(PAT_A);
    endtask

    task automatic test_priority();
        drive(PRI);
        repeat (3) tick();
        n_cmp++;
        if (fault !== 1'b0) begin
            n_err++;
            $display("FAIL priority_early: fault got %b required 0", fault);
        end
        tick();
        n_cmp++;
        if ({fault, fault_code} !== 3'b101) begin
            n_err++;
            $display("FAIL priority_code: got %b required 101", {fault, fault_code});
        end
        clear_and_recover(PAT_A);
    endtask

    task automatic test_watchdog();
        drive(PAT_B);
        tick();
        repeat (62) tick();
        n_cmp++;
        if (fault !== 1'b0) begin
            n_err++;
            $display("FAIL watchdog_62: fault got %b required 0", fault);
        end
        drive(PAT_A);
        tick();
        n_cmp++;
        if (fault !== 1'b0) begin
            n_err++;
            $display("FAIL watchdog_toggle63: fault got %b required 0", fault);
        end
        repeat (63) tick();
        n_cmp++;
        if ({fault, outs} !== {1'b0, PAT_A}) begin
            n_err++;
            $display("FAIL watchdog_63_const: got %b required %b", {fault, outs}, {1'b0, PAT_A});
        end
        tick();
        n_cmp++;
        if ({fault, fault_code, outs} !== {3'b111, ALL_Y}) begin
            n_err++;
            $display("FAIL watchdog_confirm: got %b required %b", {fault, fault_code, outs}, {3'b111, ALL_Y});
        end
    endtask

    task automatic test_recover_conflict();
        drive(CONF04);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        n_cmp++;
        if ({fault, fault_code} !== 3'b111) begin
            n_err++;
            $display("FAIL wd_clear_blocked: got %b required 111", {fault, fault_code});
        end
        drive(PAT_A);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        n_cmp++;
        if ({fault, fault_code, outs} !== {3'b000, ALL_R}) begin
            n_err++;
            $display("FAIL wd_clear_accept: got %b required %b", {fault, fault_code, outs}, {3'b000, ALL_R});
        end
        drive(CONF04);
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++;
            if ({fault, outs} !== {1'b0, ALL_R}) begin
                n_err++;
                $display("FAIL recover_filter_%0d: got %b required %b", i, {fault, outs}, {1'b0, ALL_R});
            end
        end
        tick();
        n_cmp++;
        if ({fault, fault_code, outs} !== {3'b101, ALL_Y}) begin
            n_err++;
            $display("FAIL recover_to_flash: got %b required %b", {fault, fault_code, outs}, {3'b101, ALL_Y});
        end
    endtask

    task automatic test_reset_mid();
        repeat (3) tick();
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({fault, fault_code, outs} !== {3'b000, ALL_R}) begin
            n_err++;
            $display("FAIL async_reset: got %b required %b", {fault, fault_code, outs}, {3'b000, ALL_R});
        end
        drive(PAT_A);
        repeat (2) tick();
        rst = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            n_cmp++;
            if ({fault, outs} !== {1'b0, ALL_R}) begin
                n_err++;
                $display("FAIL reset_red_%0d: got %b required %b", i, {fault, outs}, {1'b0, ALL_R});
            end
        end
        tick();
        n_cmp++;
        if ({fault, fault_code, outs} !== {3'b000, PAT_A}) begin
            n_err++;
            $display("FAIL reset_to_normal: got %b required %b", {fault, fault_code, outs}, {3'b000, PAT_A});
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_conflict();
        test_clear_ignored();
        test_illegal();
        test_priority();
        test_watchdog();
        test_recover_conflict();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
